// File: rtl/pc_gen.sv
// Program-counter generator for the RV32I fetch stage: BOOT/RUN/HALT control, prioritised redirects and traps.
// Optional misaligned-redirect trapping is enabled by defining PC_GEN_ALIGN_CHECK_EN.
module pc_gen #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = {XLEN{1'b0}},
  parameter int unsigned     STEP      = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fetch_ready_i,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            halt_i,
  input  logic            resume_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            halted_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_pc_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e          state_r;
  state_e          state_next_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] redirect_tgt_s;
  logic            pc_valid_r;
  logic            halted_r;
  logic            accept_s;
  logic            misalign_s;

`ifdef PC_GEN_ALIGN_CHECK_EN
  logic            misalign_r;
  logic [XLEN-1:0] misalign_pc_r;

  assign misalign_s     = redirect_valid_i & (redirect_pc_i[1:0] != 2'b00) & ~trap_valid_i;
  assign redirect_tgt_s = redirect_pc_i;

  // Misalign pulse coincides with trap_vec_i appearing on pc_o; offending target is held
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      misalign_r    <= 1'b0;
      misalign_pc_r <= {XLEN{1'b0}};
    end else begin
      misalign_r <= misalign_s;
      if (misalign_s) begin
        misalign_pc_r <= redirect_pc_i;
      end
    end
  end

  assign misalign_o    = misalign_r;
  assign misalign_pc_o = misalign_pc_r;
`else
  logic unused_lsb_s;

  assign unused_lsb_s   = ^redirect_pc_i[1:0];
  assign misalign_s     = 1'b0;
  assign redirect_tgt_s = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign misalign_o     = 1'b0;
  assign misalign_pc_o  = {XLEN{1'b0}};
`endif

  assign accept_s = pc_valid_r & fetch_ready_i & ~stall_i;

  // Next-PC selection; redirect/trap branches never look at fetch_ready_i
  always_comb begin
    pc_next_s = pc_r;
    if (rst_i) begin
      pc_next_s = RESET_VEC;
    end else if (trap_valid_i) begin
      pc_next_s = trap_vec_i;
    end else if (misalign_s) begin
      pc_next_s = trap_vec_i;
    end else if (redirect_valid_i) begin
      pc_next_s = redirect_tgt_s;
    end else if (accept_s) begin
      pc_next_s = pc_r + XLEN'(STEP);
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Control state transitions; halt+resume together keeps HALT
  always_comb begin
    state_next_s = state_r;
    if (rst_i) begin
      state_next_s = ST_BOOT;
    end else begin
      case (state_r)
        ST_BOOT: state_next_s = ST_RUN;
        ST_RUN: begin
          if (halt_i) begin
            state_next_s = ST_HALT;
          end else begin
            state_next_s = ST_RUN;
          end
        end
        ST_HALT: begin
          if (trap_valid_i) begin
            state_next_s = ST_RUN;
          end else if (resume_i && !halt_i) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_HALT;
          end
        end
        default: state_next_s = ST_BOOT;
      endcase
    end
  end

  // State, PC and registered status flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_BOOT;
      pc_r       <= RESET_VEC;
      pc_valid_r <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      pc_r       <= pc_next_s;
      pc_valid_r <= (state_next_s == ST_RUN);
      halted_r   <= (state_next_s == ST_HALT);
    end
  end

  assign pc_o       = pc_r;
  assign pc_valid_o = pc_valid_r;
  assign halted_o   = halted_r;
  assign pc_next_o  = pc_next_s;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; a second instance with RESET_VEC = 0xFFFFFFFC covers wrap-around.
module tb_pc_gen;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fetch_ready_i;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        trap_valid_i;
  logic [31:0] trap_vec_i;
  logic        halt_i;
  logic        resume_i;

  logic [31:0] pc_o, pc_next_o, misalign_pc_o;
  logic        pc_valid_o, halted_o, misalign_o;
  logic [31:0] w_pc_o, w_pc_next_o, w_misalign_pc_o;
  logic        w_pc_valid_o, w_halted_o, w_misalign_o;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk_i = ~clk_i;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0000_0000), .STEP(4)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .fetch_ready_i(fetch_ready_i), .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .trap_valid_i(trap_valid_i), .trap_vec_i(trap_vec_i), .halt_i(halt_i), .resume_i(resume_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .pc_next_o(pc_next_o), .halted_o(halted_o),
    .misalign_o(misalign_o), .misalign_pc_o(misalign_pc_o)
  );

  pc_gen #(.XLEN(32), .RESET_VEC(32'hFFFF_FFFC), .STEP(4)) u_dut_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .fetch_ready_i(fetch_ready_i), .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .trap_valid_i(trap_valid_i), .trap_vec_i(trap_vec_i), .halt_i(halt_i), .resume_i(resume_i),
    .pc_o(w_pc_o), .pc_valid_o(w_pc_valid_o), .pc_next_o(w_pc_next_o), .halted_o(w_halted_o),
    .misalign_o(w_misalign_o), .misalign_pc_o(w_misalign_pc_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; fetch_ready_i = 1'b1; stall_i = 1'b0;
    redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
    trap_valid_i = 1'b0; trap_vec_i = 32'h0; halt_i = 1'b0; resume_i = 1'b0;

    // Reset held for two edges
    tick(); tick();
    check_val("rst_pc", pc_o, 32'h0);
    check_val("rst_valid", 32'(pc_valid_o), 32'h0);
    check_val("rst_halted", 32'(halted_o), 32'h0);
    check_val("rst_misalign", 32'(misalign_o), 32'h0);
    check_val("rst_misalign_pc", misalign_pc_o, 32'h0);
    check_val("rst_wrap_pc", w_pc_o, 32'hFFFF_FFFC);

    // Boot then sequential fetch
    rst_i = 1'b0;
    tick();
    check_val("boot_valid", 32'(pc_valid_o), 32'h1);
    check_val("boot_pc", pc_o, 32'h0);
    check_val("boot_wrap_pc", w_pc_o, 32'hFFFF_FFFC);
    tick();
    check_val("seq_pc4", pc_o, 32'h4);
    check_val("wrap_pc0", w_pc_o, 32'h0);
    tick();
    check_val("seq_pc8", pc_o, 32'h8);
    tick(); tick();
    check_val("seq_pc10", pc_o, 32'h10);

    // Backpressure via fetch_ready_i, then via stall_i
    fetch_ready_i = 1'b0;
    repeat (3) tick();
    check_val("bp_hold_pc", pc_o, 32'h10);
    check_val("bp_hold_valid", 32'(pc_valid_o), 32'h1);
    fetch_ready_i = 1'b1;
    tick();
    check_val("bp_release_pc", pc_o, 32'h14);
    stall_i = 1'b1;
    repeat (3) tick();
    check_val("stall_hold_pc", pc_o, 32'h14);
    check_val("stall_hold_valid", 32'(pc_valid_o), 32'h1);
    stall_i = 1'b0;
    tick();
    check_val("stall_release_pc", pc_o, 32'h18);

    // Trap beats redirect; redirect ignores fetch_ready_i
    trap_valid_i = 1'b1; trap_vec_i = 32'h100;
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h200;
    #1 check_val("prio_pc_next", pc_next_o, 32'h100);
    tick();
    check_val("prio_pc", pc_o, 32'h100);
    trap_valid_i = 1'b0; fetch_ready_i = 1'b0;
    #1 check_val("redir_pc_next", pc_next_o, 32'h200);
    tick();
    check_val("redir_pc", pc_o, 32'h200);
    redirect_pc_i = 32'h20;
    tick();
    redirect_valid_i = 1'b0;
    check_val("redir20_pc", pc_o, 32'h20);

    // Halt, redirect while halted, resume
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    check_val("halt_valid", 32'(pc_valid_o), 32'h0);
    check_val("halt_halted", 32'(halted_o), 32'h1);
    check_val("halt_pc", pc_o, 32'h20);
    fetch_ready_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h40;
    tick();
    redirect_valid_i = 1'b0;
    check_val("halt_redir_pc", pc_o, 32'h40);
    check_val("halt_redir_halted", 32'(halted_o), 32'h1);
    tick();
    check_val("halt_no_fetch_pc", pc_o, 32'h40);
    resume_i = 1'b1;
    tick();
    resume_i = 1'b0;
    check_val("resume_valid", 32'(pc_valid_o), 32'h1);
    check_val("resume_halted", 32'(halted_o), 32'h0);
    check_val("resume_pc", pc_o, 32'h40);
    tick();
    check_val("resume_fetch_pc", pc_o, 32'h44);

    // Halt+resume together stays halted; trap exits to RUN
    halt_i = 1'b1; fetch_ready_i = 1'b0;
    tick();
    check_val("halt2_halted", 32'(halted_o), 32'h1);
    resume_i = 1'b1;
    tick();
    halt_i = 1'b0; resume_i = 1'b0;
    check_val("halt_resume_both", 32'(halted_o), 32'h1);
    trap_valid_i = 1'b1; trap_vec_i = 32'h300;
    tick();
    trap_valid_i = 1'b0;
    check_val("halt_trap_pc", pc_o, 32'h300);
    check_val("halt_trap_valid", 32'(pc_valid_o), 32'h1);
    check_val("halt_trap_halted", 32'(halted_o), 32'h0);

    // Misaligned redirect
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h102; trap_vec_i = 32'h80;
`ifdef PC_GEN_ALIGN_CHECK_EN
    #1 check_val("mis_pc_next", pc_next_o, 32'h80);
    tick();
    redirect_valid_i = 1'b0;
    check_val("mis_pc", pc_o, 32'h80);
    check_val("mis_pulse", 32'(misalign_o), 32'h1);
    check_val("mis_capture", misalign_pc_o, 32'h102);
    tick();
    check_val("mis_pulse_end", 32'(misalign_o), 32'h0);
    check_val("mis_capture_held", misalign_pc_o, 32'h102);
`else
    #1 check_val("mis_pc_next", pc_next_o, 32'h100);
    tick();
    redirect_valid_i = 1'b0;
    check_val("mis_pc", pc_o, 32'h100);
    check_val("mis_pulse", 32'(misalign_o), 32'h0);
    check_val("mis_capture", misalign_pc_o, 32'h0);
`endif

    // Reset mid-operation overrides trap and halt; halt in BOOT ignored
    rst_i = 1'b1; trap_valid_i = 1'b1; halt_i = 1'b1; fetch_ready_i = 1'b1;
    #1 check_val("midrst_pc_next", pc_next_o, 32'h0);
    tick();
    check_val("midrst_pc", pc_o, 32'h0);
    check_val("midrst_valid", 32'(pc_valid_o), 32'h0);
    check_val("midrst_halted", 32'(halted_o), 32'h0);
    check_val("midrst_misalign_pc", misalign_pc_o, 32'h0);
    rst_i = 1'b0; trap_valid_i = 1'b0;
    tick();
    halt_i = 1'b0;
    check_val("boot_halt_valid", 32'(pc_valid_o), 32'h1);
    check_val("boot_halt_halted", 32'(halted_o), 32'h0);
    check_val("boot_halt_pc", pc_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RV32I fetch stage. It holds the architectural PC and advances it by a fixed step when the instruction memory accepts a fetch. It applies branch/jump redirects and trap vectors with fixed priority, and supports halt/resume with a misaligned-target trap. It is a drop-in successor to the plain PC register and feeds the instruction-memory address and the PC+4 adder path.

## Interface
Parameters:
- XLEN, 32, PC width in bits
- RESET_VEC, 0, PC value loaded on reset (XLEN bits)
- STEP, 4, sequential increment in bytes

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- fetch_ready_i  in  1  instruction memory accepts pc_o this cycle
- stall_i  in  1  pipeline stall; PC holds
- redirect_valid_i  in  1  branch/jump taken
- redirect_pc_i  in  XLEN  branch/jump target
- trap_valid_i  in  1  trap/exception request
- trap_vec_i  in  XLEN  trap handler address
- halt_i  in  1  request halt (1-cycle pulse or level)
- resume_i  in  1  leave HALT
- pc_o  out  XLEN  current fetch address (registered)
- pc_valid_o  out  1  pc_o is a valid fetch request (registered)
- pc_next_o  out  XLEN  combinational value pc_o takes at next edge
- halted_o  out  1  block is in HALT (registered)
- misalign_o  out  1  1-cycle pulse, misaligned redirect trapped
- misalign_pc_o  out  XLEN  offending target, held until next misalign

## Operation
- States: BOOT, RUN, HALT. Reset → BOOT. BOOT → RUN unconditionally after one cycle.
- pc_valid_o = 1 only in RUN.
- Fetch accepted = pc_valid_o & fetch_ready_i & ~stall_i.
- Next-PC priority, highest first:
  - rst_i → RESET_VEC
  - trap_valid_i → trap_vec_i
  - misaligned redirect → trap_vec_i
  - redirect_valid_i → redirect_pc_i
  - fetch accepted → pc_o + STEP
  - otherwise hold
- Redirect and trap apply regardless of stall_i and fetch_ready_i. The unaccepted pc_o is discarded.
- Increment wraps modulo 2^XLEN; no overflow flag.
- HALT:
  - halt_i in RUN → HALT at the next edge. A simultaneous redirect or trap still updates the PC.
  - In HALT: pc_valid_o = 0 and halted_o = 1. Redirects update pc_o; the block stays halted.
  - trap_valid_i in HALT loads trap_vec_i and returns to RUN.
  - resume_i in HALT → RUN. halt_i and resume_i together in HALT → stays HALT.
  - halt_i in BOOT is ignored.
- Misaligned redirect (macro enabled): redirect_valid_i with redirect_pc_i[1:0] ≠ 0 and no trap_valid_i.
  - PC loads trap_vec_i.
  - misalign_o pulses for one cycle.
  - misalign_pc_o captures redirect_pc_i.

## Timing
- Reset values:
  - pc_o = RESET_VEC
  - pc_valid_o = 0, halted_o = 0
  - misalign_o = 0, misalign_pc_o = 0
  - state = BOOT
- First valid fetch: pc_valid_o = 1 with pc_o = RESET_VEC, two edges after rst_i is sampled high and then released.
- Redirect/trap latency: target appears on pc_o one edge after request. pc_next_o shows it in the same cycle.
- rst_i asserted mid-operation overrides all inputs in that cycle, including trap and halt.
- misalign_o is asserted in the cycle pc_o = trap_vec_i first appears.
- pc_next_o is purely combinational from current state and inputs. It must not depend on fetch_ready_i when redirect or trap is active.

## Configuration
- PC_GEN_ALIGN_CHECK_EN defined:
  - Misaligned-redirect detection as above.
  - misalign_o and misalign_pc_o are live.
- Not defined:
  - redirect_pc_i[1:0] is masked to 0 and the redirect is always taken.
  - misalign_o and misalign_pc_o are tied to 0; no capture register.

## Test plan
- Reset/boot: rst_i high 2 cycles, then low, fetch_ready_i = 1.
  - pc_valid_o = 0 for 1 cycle, then pc_o = 0x0, 0x4, 0x8 on consecutive cycles.
- Backpressure: fetch_ready_i = 0 for 3 cycles at pc_o = 0x10.
  - pc_o holds 0x10 with pc_valid_o = 1; advances to 0x14 on the first ready cycle.
  - Repeat with stall_i = 1: same result.
- Priority: trap_valid_i (trap_vec_i = 0x100) and redirect_valid_i (0x200) in the same cycle.
  - pc_o = 0x100.
  - Redirect alone with fetch_ready_i = 0: pc_o = 0x200.
- Wrap: RESET_VEC = 0xFFFFFFFC, fetch accepted.
  - pc_o = 0x00000000.
- Halt/resume: halt_i at pc_o = 0x20.
  - pc_valid_o = 0, halted_o = 1.
  - Redirect to 0x40 while halted: pc_o = 0x40, still halted.
  - resume_i: pc_valid_o = 1 at 0x40.
  - Repeat with trap_valid_i instead of resume_i: exits to RUN at trap_vec_i.
- Misalign (macro on): redirect to 0x102, trap_vec_i = 0x80.
  - pc_o = 0x80, misalign_o high 1 cycle, misalign_pc_o = 0x102.
  - Macro off: pc_o = 0x100, misalign_o = 0.
